conv_out_collector: RTL and testbench
=====================================

# conv_out_collector

Result-side endpoint of the 5x5 convolution datapath. Accepts the stream of 32-bit `finalOutput` words produced by `mmu` in raster order (channel, then row, then column), writes each word into an on-chip feature-map buffer, and signals completion. Downstream logic such as pooling or host readback then reads the buffer through a registered read port.

## Interface
Parameters:
- `OUT_CHANNEL`, default 6: output channels per frame.
- `OUT_ROW`, default 28: output rows per channel.
- `OUT_COL`, default 28: output columns per row.
- `ADDR_W`, default 13: buffer address width. Must satisfy 2^ADDR_W ≥ OUT_CHANNEL*OUT_ROW*OUT_COL (4704).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms collection of a new frame.
- `in_valid` in 1: `in_data` holds a result.
- `in_ready` out 1: collector accepts a result this cycle.
- `in_data` in 32: result word (IEEE-754 single, `mmu.finalOutput`).
- `busy` out 1: high while collecting.
- `done` out 1: high from the frame's final write until the next `start` or `rst`.
- `ch_idx` out 3, `row_idx` out 5, `col_idx` out 5: position of the next expected word.
- `rd_en` in 1: read strobe.
- `rd_addr` in ADDR_W: read address, computed as ch*OUT_ROW*OUT_COL + row*OUT_COL + col.
- `rd_data` out 32: read data.

## Operation
- The FSM has three states.
  - IDLE → COLLECT on `start`.
  - COLLECT → DONE on acceptance of the last word (ch=OUT_CHANNEL-1, row=OUT_ROW-1, col=OUT_COL-1).
  - DONE → COLLECT on `start`.
- `start` in IDLE or DONE clears all counters, the write address and `done`.
- `start` in COLLECT is ignored.
- `in_ready` = (state==COLLECT). A transfer occurs when `in_valid && in_ready`. `in_valid` in other states is dropped without side effects.
- On each transfer the word is written to `mem[wr_addr]`, then `wr_addr` increments.
- Counter updates on each transfer:
  - col increments.
  - At col=OUT_COL-1, col wraps to 0 and row increments.
  - At row=OUT_ROW-1 (with the col wrap), row wraps to 0 and ch increments.
- `wr_addr` is a running counter. Do not use multipliers.
- The read port works in every state. A read of an out-of-range address (≥4704) returns 0.
- A read and a write to the same address in the same cycle returns the old contents.
- `rst` mid-frame aborts the frame: FSM goes to IDLE and counters clear. Buffer contents are retained and undefined for the aborted frame.

## Timing
- Reset values:
  - `in_ready`=0, `busy`=0, `done`=0.
  - `ch_idx`/`row_idx`/`col_idx`=0.
  - `rd_data`=0.
  - FSM=IDLE.
  - Memory is not reset.
- `in_ready` and `busy` rise the cycle after `start`.
- One transfer per cycle is sustained with no bubbles. A full frame takes 4704 transfer cycles.
- `done` rises, and `busy`/`in_ready` fall, in the cycle after the final transfer edge.
- Read latency is 1 cycle: `rd_data` updates on the edge after `rd_en` and holds when `rd_en`=0.
- A write is visible to reads starting on the next cycle.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- `CONV_OUT_RELU_EN` defined: a word with `in_data[31]`=1 is stored as 32'h0000_0000, and all other words are stored unchanged. This applies ReLU to the IEEE-754 value, including -0.0.
- `CONV_OUT_RELU_EN` undefined: words are stored bit-exact.
- Handshake and timing are identical in both builds.

## Test plan
- **Reset state:** `rst` for 2 cycles → all outputs 0 and `in_ready`=0. Then `in_valid`=1 with `start` held low → no writes; `rd_addr`=0 reads its pre-reset value.
- **Full frame streaming:** `start`, then 4704 back-to-back words with `in_data`=index → `done` rises exactly one cycle after the 4704th transfer. `rd_addr`=785 returns 785, and `ch_idx`/`row_idx`/`col_idx` equal 0/0/0 after completion (after wrap: ch=6 is never exposed).
- **Throttled input:** random `in_valid` gaps → `col_idx` advances only on transfers. Word at ch=2,row=27,col=27 lands at address 2351.
- **Restart:** `start` while `busy` is ignored and `col_idx` keeps counting. `start` in DONE → `done`=0 next cycle and the next word overwrites address 0.
- **Reset mid-frame:** `rst` after 100 words → IDLE, `col_idx`=0. A following `start` rewrites from address 0.
- **ReLU build:** with `CONV_OUT_RELU_EN`, inputs 32'hBF80_0000 (-1.0) and 32'h8000_0000 read back 0, and 32'h3F80_0000 reads back unchanged. Without the macro, all three read back bit-exact.

Source files
------------

// File: rtl/conv_out_collector.sv
// conv_out_collector
//
// Result-side endpoint of the 5x5 convolution datapath. Collects a frame of 32-bit result
// words arriving in raster order (channel, row, column) into an on-chip feature-map buffer.
// It raises done after the last word of the frame is written. The buffer is read back
// through a registered port with 1-cycle latency.
//
// Build option:
//   CONV_OUT_RELU_EN  defined   -> words with bit 31 set (negative, incl. -0.0) store as 0
//                     undefined -> words store bit-exact
//
// Ports:
//   clk       in   single rising-edge clock
//   rst       in   synchronous active-high reset (aborts a frame, buffer retained)
//   start     in   one-cycle pulse, arms a new frame (ignored while collecting)
//   in_valid  in   in_data holds a result word
//   in_ready  out  collector accepts a word this cycle
//   in_data   in   result word (IEEE-754 single)
//   busy      out  high while collecting
//   done      out  high from the final write until the next start/rst
//   ch_idx    out  channel of the next expected word
//   row_idx   out  row of the next expected word
//   col_idx   out  column of the next expected word
//   rd_en     in   read strobe
//   rd_addr   in   read address = ch*OUT_ROW*OUT_COL + row*OUT_COL + col
//   rd_data   out  read data, 0 for out-of-range addresses

module conv_out_collector #(
    parameter int unsigned OUT_CHANNEL = 6,
    parameter int unsigned OUT_ROW     = 28,
    parameter int unsigned OUT_COL     = 28,
    parameter int unsigned ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              busy,
    output logic              done,
    output logic [2:0]        ch_idx,
    output logic [4:0]        row_idx,
    output logic [4:0]        col_idx,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data
);

    localparam int unsigned Depth = OUT_CHANNEL * OUT_ROW * OUT_COL;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       mem [Depth];

    logic        xfer;
    logic        col_last;
    logic        row_last;
    logic        ch_last;
    logic [31:0] wr_data;
    logic        rd_in_range;

    // in_ready is a registered copy of (state_q == StCollect).
    assign xfer     = in_valid && in_ready;
    assign col_last = (col_idx == 5'(OUT_COL - 1));
    assign row_last = (row_idx == 5'(OUT_ROW - 1));
    assign ch_last  = (ch_idx == 3'(OUT_CHANNEL - 1));

    assign rd_in_range = (rd_addr < ADDR_W'(Depth));

`ifdef CONV_OUT_RELU_EN
    // Sign bit set covers every negative value and -0.0.
    assign wr_data = in_data[31] ? 32'h0000_0000 : in_data;
`else
    assign wr_data = in_data;
`endif

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ch_idx    <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            wr_addr_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q   <= StCollect;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        ch_idx    <= '0;
                        row_idx   <= '0;
                        col_idx   <= '0;
                        wr_addr_q <= '0;
                    end
                end
                StCollect: begin
                    if (in_valid) begin
                        if (col_last && row_last && ch_last) begin
                            // Final word: wrap everything so ch=OUT_CHANNEL is never exposed.
                            state_q   <= StDone;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            ch_idx    <= '0;
                            row_idx   <= '0;
                            col_idx   <= '0;
                            wr_addr_q <= '0;
                        end else begin
                            wr_addr_q <= wr_addr_q + ADDR_W'(1);
                            if (col_last) begin
                                col_idx <= '0;
                                if (row_last) begin
                                    row_idx <= '0;
                                    ch_idx  <= ch_idx + 3'd1;
                                end else begin
                                    row_idx <= row_idx + 5'd1;
                                end
                            end else begin
                                col_idx <= col_idx + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Feature-map buffer, not reset.
    always_ff @(posedge clk) begin
        if (xfer && !rst) begin
            mem[wr_addr_q] <= wr_data;
        end
    end

    // Registered read port; reads old contents on a same-address write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 32'h0;
        end else if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_addr] : 32'h0;
        end
    end

endmodule

// File: tb/tb_conv_out_collector.sv
module tb_conv_out_collector;

    localparam int unsigned NCH   = 6;
    localparam int unsigned NR    = 28;
    localparam int unsigned NC    = 28;
    localparam int unsigned AW    = 13;
    localparam int unsigned DEPTH = NCH * NR * NC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          busy;
    logic          done;
    logic [2:0]    ch_idx;
    logic [4:0]    row_idx;
    logic [4:0]    col_idx;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;

    always #5 clk = ~clk;

    conv_out_collector #(
        .OUT_CHANNEL(NCH),
        .OUT_ROW    (NR),
        .OUT_COL    (NC),
        .ADDR_W     (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .busy    (busy),
        .done    (done),
        .ch_idx  (ch_idx),
        .row_idx (row_idx),
        .col_idx (col_idx),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame progress is a plain word count; position is derived arithmetically.
    logic [31:0] mmem   [DEPTH];
    bit          mknown [DEPTH];
    bit          m_collect  = 0;
    bit          m_done     = 0;
    int          m_n        = 0;
    logic [31:0] m_rd       = 0;
    bit          m_rd_known = 1;
    logic [31:0] word_2351  = 0;

    function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef CONV_OUT_RELU_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    // One clock: model follows the inputs held across the edge, then outputs are compared.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (m_collect) begin
                for (int i = 0; i < m_n; i++) mknown[i] = 0;
            end
            m_collect  = 0;
            m_done     = 0;
            m_n        = 0;
            m_rd       = 0;
            m_rd_known = 1;
        end else begin
            if (rd_en) begin
                if (int'(rd_addr) >= DEPTH) begin
                    m_rd       = 0;
                    m_rd_known = 1;
                end else begin
                    m_rd       = mmem[rd_addr];
                    m_rd_known = mknown[rd_addr];
                end
            end
            if (m_collect && in_valid) begin
                if (m_n / (NR * NC) == 2 && (m_n / NC) % NR == 27 && m_n % NC == 27)
                    word_2351 = in_data;
                mmem[m_n]   = stored(in_data);
                mknown[m_n] = 1;
                m_n++;
                if (m_n == DEPTH) begin
                    m_collect = 0;
                    m_done    = 1;
                    m_n       = 0;
                end
            end else if (start && !m_collect) begin
                m_collect = 1;
                m_done    = 0;
                m_n       = 0;
            end
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(m_collect));
        check("busy", 32'(busy), 32'(m_collect));
        check("done", 32'(done), 32'(m_done));
        check("col_idx", 32'(col_idx), 32'(m_n % NC));
        check("row_idx", 32'(row_idx), 32'((m_n / NC) % NR));
        check("ch_idx", 32'(ch_idx), 32'(m_n / (NR * NC)));
        if (m_rd_known) check("rd_data", rd_data, m_rd);
    endtask

    initial begin
        int cyc;
        rst = 1; start = 0; in_valid = 0; in_data = 0; rd_en = 0; rd_addr = '0;

        // Reset state, then input without start is dropped.
        tick(); tick();
        rst = 0;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 0;

        // Full back-to-back frame, data = index.
        start = 1; tick(); start = 0;
        in_valid = 1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            in_data = i;
            tick();
        end
        in_valid = 0;
        check("frame1_done", 32'(done), 32'd1);
        check("frame1_idx_wrap", {ch_idx, row_idx, col_idx}, 32'd0);
        rd_en = 1; rd_addr = AW'(785); tick();
        check("rd_785", rd_data, 32'd785);
        rd_en = 0; rd_addr = AW'(3); tick(); tick();
        check("rd_hold", rd_data, 32'd785);
        rd_en = 1; rd_addr = AW'(5000); tick();
        check("rd_oor_5000", rd_data, 32'd0);
        rd_addr = AW'(8191); tick();
        rd_en = 0;

        // Reset after a frame: no writes without start, buffer retained.
        rst = 1; tick(); tick(); rst = 0;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            tick();
        end
        in_valid = 0;
        rd_en = 1; rd_addr = '0; tick();
        check("pre_reset_word", rd_data, 32'd0);
        rd_en = 0;

        // Throttled random frame with ignored starts and reads incl. read-during-write.
        start = 1; tick(); start = 0;
        cyc = 0;
        while (m_collect && cyc < 30000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            case (m_n)
                10:      in_data = 32'hBF80_0000;
                11:      in_data = 32'h8000_0000;
                12:      in_data = 32'h3F80_0000;
                default: in_data = $urandom;
            endcase
            start = ($urandom_range(0, 49) == 0);
            rd_en = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) rd_addr = AW'(m_n);
            else rd_addr = AW'($urandom_range(0, 8191));
            tick();
            cyc++;
        end
        start = 0; in_valid = 0; rd_en = 0;
        check("frame2_done", 32'(done), 32'd1);
        rd_en = 1; rd_addr = AW'(2351); tick();
        check("rd_2351", rd_data, stored(word_2351));
`ifdef CONV_OUT_RELU_EN
        rd_addr = AW'(10); tick(); check("relu_neg1", rd_data, 32'h0000_0000);
        rd_addr = AW'(11); tick(); check("relu_negz", rd_data, 32'h0000_0000);
`else
        rd_addr = AW'(10); tick(); check("raw_neg1", rd_data, 32'hBF80_0000);
        rd_addr = AW'(11); tick(); check("raw_negz", rd_data, 32'h8000_0000);
`endif
        rd_addr = AW'(12); tick(); check("pos_one", rd_data, 32'h3F80_0000);
        rd_en = 0;

        // Restart from done; first word overwrites address 0.
        start = 1; tick(); start = 0;
        check("restart_done_clr", 32'(done), 32'd0);
        in_valid = 1; in_data = 32'h1234_5678; tick();
        in_valid = 0; rd_en = 1; rd_addr = '0; tick();
        check("restart_addr0", rd_data, 32'h1234_5678);
        rd_en = 0;
        in_valid = 1;
        for (int i = 1; i < 100; i++) begin
            in_data = $urandom;
            start = (i == 40);
            tick();
        end
        start = 0; in_valid = 0;
        check("ignored_start_col", 32'(col_idx), 32'(100 % NC));

        // Reset mid-frame, then a new frame rewrites from address 0.
        rst = 1; tick(); rst = 0;
        check("abort_col", 32'(col_idx), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        start = 1; tick(); start = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hA5A5_0000 + i;
            tick();
        end
        in_valid = 0;
        rd_en = 1; rd_addr = '0; tick();
        check("rewrite_addr0", rd_data, 32'hA5A5_0000);

        // A few random reads across the whole address space.
        for (int i = 0; i < 40; i++) begin
            rd_addr = AW'($urandom_range(0, 8191));
            tick();
        end
        rd_en = 0; tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
